// File: rtl/wired_pkg.sv
// Shared types for the wired ALU issue queue: one queue entry and the issued payload.
package wired_pkg;

   localparam int WIRED_RID_W = 6;

   typedef struct packed {
      logic                   valid;
      logic                   r0_rdy;
      logic [WIRED_RID_W-1:0] r0_tag;
      logic [31:0]            r0;
      logic                   r1_rdy;
      logic [WIRED_RID_W-1:0] r1_tag;
      logic [31:0]            r1;
      logic [31:0]            pc;
      logic [11:0]            selimm;
      logic [2:0]             grand_op;
      logic [2:0]             op;
      logic [WIRED_RID_W-1:0] wtag;
   } iq_entry_t;

   typedef struct packed {
      logic [31:0]            r0;
      logic [31:0]            r1;
      logic [31:0]            pc;
      logic [11:0]            selimm;
      logic [2:0]             grand_op;
      logic [2:0]             op;
      logic [WIRED_RID_W-1:0] wtag;
   } iss_pkt_t;

   function automatic iss_pkt_t to_pkt(iq_entry_t e);
      iss_pkt_t p;
      p.r0       = e.r0;
      p.r1       = e.r1;
      p.pc       = e.pc;
      p.selimm   = e.selimm;
      p.grand_op = e.grand_op;
      p.op       = e.op;
      p.wtag     = e.wtag;
      return p;
   endfunction

endpackage

// File: rtl/wired_iq_entry.sv
// One issue-queue slot: applies result wakeups to the entry it is about to hold and registers it.
module wired_iq_entry
   import wired_pkg::*;
#(
   parameter int WKUP_N = 2,
   parameter int RID_W  = 6
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  iq_entry_t                      cand_i,
   input  logic                           clr_i,
   input  logic [WKUP_N-1:0]              wkup_valid_i,
   input  logic [WKUP_N-1:0][RID_W-1:0]   wkup_tag_i,
   input  logic [WKUP_N-1:0][31:0]        wkup_data_i,
   output iq_entry_t                      woke_o,
   output iq_entry_t                      ent_o
);

   iq_entry_t ent_d, ent_q;

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      woke_o = cand_i;
      // Walk ports high to low so the lowest matching port is the last write.
      for (int p = WKUP_N - 1; p >= 0; p--) begin
         if (wkup_valid_i[p] && cand_i.valid) begin
            if (!cand_i.r0_rdy && cand_i.r0_tag == WIRED_RID_W'(wkup_tag_i[p])) begin
               woke_o.r0_rdy = 1'b1;
               woke_o.r0     = wkup_data_i[p];
            end
            if (!cand_i.r1_rdy && cand_i.r1_tag == WIRED_RID_W'(wkup_tag_i[p])) begin
               woke_o.r1_rdy = 1'b1;
               woke_o.r1     = wkup_data_i[p];
            end
         end
      end
   end

   always_comb begin
      ent_d       = woke_o;
      ent_d.valid = woke_o.valid && !clr_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: only the valid bit needs reset; payload of an invalid slot is never observed.
         ent_q.valid <= 1'b0;
      end else begin
         // NOTE: sequential state always uses non-blocking assignment.
         ent_q <= ent_d;
      end
   end

   assign ent_o = ent_q;

endmodule

// File: rtl/wired_alu_iq.sv
// Collapsing, age-ordered ALU issue queue with wakeup/forwarding and a registered issue port.
module wired_alu_iq
   import wired_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int RID_W  = 6,
   parameter int WKUP_N = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush_i,
   input  logic                         disp_valid_i,
   output logic                         disp_ready_o,
   input  logic [31:0]                  disp_r0_i,
   input  logic [31:0]                  disp_r1_i,
   input  logic [31:0]                  disp_pc_i,
   input  logic                         disp_r0_rdy_i,
   input  logic                         disp_r1_rdy_i,
   input  logic [RID_W-1:0]             disp_r0_tag_i,
   input  logic [RID_W-1:0]             disp_r1_tag_i,
   input  logic [RID_W-1:0]             disp_wtag_i,
   input  logic [11:0]                  disp_selimm_i,
   input  logic [2:0]                   disp_grand_op_i,
   input  logic [2:0]                   disp_op_i,
   input  logic [WKUP_N-1:0]            wkup_valid_i,
   input  logic [WKUP_N-1:0][RID_W-1:0] wkup_tag_i,
   input  logic [WKUP_N-1:0][31:0]      wkup_data_i,
   output logic                         iss_valid_o,
   input  logic                         iss_ready_i,
   output logic [31:0]                  iss_r0_o,
   output logic [31:0]                  iss_r1_o,
   output logic [31:0]                  iss_pc_o,
   output logic [11:0]                  iss_selimm_o,
   output logic [2:0]                   iss_grand_op_o,
   output logic [2:0]                   iss_op_o,
   output logic [RID_W-1:0]             iss_wtag_o
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;

   iq_entry_t     ent_q   [DEPTH];
   iq_entry_t     ent_ext [DEPTH+1];
   iq_entry_t     cand    [DEPTH];
   iq_entry_t     woke    [DEPTH];
   iq_entry_t     disp_ent;
   logic [DEPTH-1:0] clr;

   logic [CW-1:0] count_q, count_d, wpos;
   logic [IW-1:0] sel_idx;
   logic          sel_found, can_load, enq, deq, direct;
   logic          iss_valid_q, iss_valid_d;
   iss_pkt_t      iss_q, iss_d;

   assign disp_ready_o = (count_q < CW'(DEPTH)) && !flush_i;
   assign enq          = disp_valid_i && disp_ready_o;
   assign can_load     = !iss_valid_q || iss_ready_i;

   always_comb begin
      disp_ent          = '0;
      disp_ent.valid    = 1'b1;
      disp_ent.r0_rdy   = disp_r0_rdy_i;
      disp_ent.r0_tag   = WIRED_RID_W'(disp_r0_tag_i);
      disp_ent.r0       = disp_r0_i;
      disp_ent.r1_rdy   = disp_r1_rdy_i;
      disp_ent.r1_tag   = WIRED_RID_W'(disp_r1_tag_i);
      disp_ent.r1       = disp_r1_i;
      disp_ent.pc       = disp_pc_i;
      disp_ent.selimm   = disp_selimm_i;
      disp_ent.grand_op = disp_grand_op_i;
      disp_ent.op       = disp_op_i;
      disp_ent.wtag     = WIRED_RID_W'(disp_wtag_i);
   end

   // Select: oldest entry with both operands ready, from registered state only.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (ent_q[i].valid && ent_q[i].r0_rdy && ent_q[i].r1_rdy) begin
            sel_found = 1'b1;
            sel_idx   = IW'(i);
         end
      end
   end

   assign deq  = can_load && sel_found && !flush_i;
   assign wpos = deq ? count_q - CW'(1) : count_q;

   // Collapse: slots at or above the dequeued one take their upper neighbour.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_ext[i] = ent_q[i];
      end
      ent_ext[DEPTH] = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cand[i] = ent_q[i];
         if (deq && CW'(i) >= CW'(sel_idx)) begin
            cand[i] = ent_ext[i+1];
         end
         if (enq && CW'(i) == wpos) begin
            cand[i] = disp_ent;
         end
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_ent
      wired_iq_entry #(
         .WKUP_N (WKUP_N),
         .RID_W  (RID_W)
      ) u_ent (
         .clk          (clk),
         .rst_n        (rst_n),
         .cand_i       (cand[g]),
         .clr_i        (clr[g]),
         .wkup_valid_i (wkup_valid_i),
         .wkup_tag_i   (wkup_tag_i),
         .wkup_data_i  (wkup_data_i),
         .woke_o       (woke[g]),
         .ent_o        (ent_q[g])
      );
   end

   // A fully ready dispatch goes straight to the issue register when nothing older can issue.
   assign direct = can_load && !sel_found && enq &&
                   woke[wpos[IW-1:0]].r0_rdy && woke[wpos[IW-1:0]].r1_rdy;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         clr[i] = flush_i || (direct && CW'(i) == wpos);
      end
      if (flush_i) begin
         count_d = '0;
      end else begin
         count_d = count_q + CW'(enq) - CW'(deq) - CW'(direct);
      end
   end

   always_comb begin
      iss_valid_d = iss_valid_q;
      iss_d       = iss_q;
      if (flush_i) begin
         iss_valid_d = 1'b0;
      end else if (deq) begin
         iss_valid_d = 1'b1;
         iss_d       = to_pkt(ent_q[sel_idx]);
      end else if (direct) begin
         iss_valid_d = 1'b1;
         iss_d       = to_pkt(woke[wpos[IW-1:0]]);
      end else if (iss_ready_i) begin
         iss_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q     <= '0;
         iss_valid_q <= 1'b0;
         iss_q       <= '0;
      end else begin
         count_q     <= count_d;
         iss_valid_q <= iss_valid_d;
         iss_q       <= iss_d;
      end
   end

   assign iss_valid_o    = iss_valid_q;
   assign iss_r0_o       = iss_q.r0;
   assign iss_r1_o       = iss_q.r1;
   assign iss_pc_o       = iss_q.pc;
   assign iss_selimm_o   = iss_q.selimm;
   assign iss_grand_op_o = iss_q.grand_op;
   assign iss_op_o       = iss_q.op;
   assign iss_wtag_o     = RID_W'(iss_q.wtag);

endmodule

// File: doc/wired_alu_iq.md
WIRED_ALU_IQ -- requirements
Module: wired_alu_iq

Interface
REQ-001 Parameter DEPTH, default 4: issue-queue entry count (power of two, 2..8).
REQ-002 Parameter RID_W, default 6: physical register tag width.
REQ-003 Parameter WKUP_N, default 2: number of wakeup/forward ports.
REQ-004 One clock and one reset; reset is asynchronous and active-low; ports are named clk and rst_n.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 flush_i  in  1  pipeline flush; drop all queued and issued-pending work.
REQ-008 disp_valid_i / disp_ready_o  in / out  1 / 1  dispatch handshake.
REQ-009 disp_r0_i, disp_r1_i, disp_pc_i  in  32 each  operand values (valid when matching rdy bit set) and PC.
REQ-010 disp_r0_rdy_i, disp_r1_rdy_i  in  1 each  operand already available.
REQ-011 disp_r0_tag_i, disp_r1_tag_i, disp_wtag_i  in  RID_W each  source tags, destination tag.
REQ-012 disp_selimm_i  in  12, disp_grand_op_i  in  3, disp_op_i  in  3  ALU control fields, carried unchanged.
REQ-013 wkup_valid_i  in  WKUP_N; wkup_tag_i  in  WKUP_N x RID_W; wkup_data_i  in  WKUP_N x 32  result broadcast.
REQ-014 iss_valid_o / iss_ready_i  out / in  1 / 1  issue handshake to the ALU stage.
REQ-015 iss_r0_o, iss_r1_o, iss_pc_o  out  32 each; iss_selimm_o  out  12; iss_grand_op_o, iss_op_o  out  3 each; iss_wtag_o  out  RID_W.

Function
REQ-016 Queue is collapsing and age-ordered: entry 0 oldest; occupancy count 0..DEPTH.
REQ-017 disp_ready_o = (count < DEPTH) && !flush_i; it does not depend on same-cycle dequeue.
REQ-018 Enqueue on disp_valid_i && disp_ready_o, written at the edge into slot count, or slot count-1 when an entry dequeues in the same cycle.
REQ-019 Dispatch bypass: a source not ready at dispatch whose tag matches a valid wakeup port in the same cycle is stored ready with that port's data.
REQ-020 Wakeup: each valid, non-ready source whose tag matches a valid wakeup port captures the data and sets ready at the edge; on multiple matches the lowest port index wins.
REQ-021 Select: the lowest-index entry with both sources ready, evaluated combinationally from registered state.
REQ-022 Output register loads when (!iss_valid_o || iss_ready_i) and a selected entry exists; the selected entry is removed at that same edge, and entries above it shift down one slot.
REQ-023 When iss_valid_o && !iss_ready_i, all iss_* outputs hold stable and no entry dequeues.
REQ-024 When iss_ready_i is high and no entry is selectable, iss_valid_o clears at the edge.
REQ-025 Minimum latency: dispatch with both sources ready at cycle N -> iss_valid_o high in cycle N+1; throughput is 1 issue/cycle.
REQ-026 Entries shifting down keep their ready/data state and also apply wakeups in the same cycle.
REQ-027 flush_i has priority: at the edge all entries are invalidated and iss_valid_o cleared; dispatch and wakeup in that cycle are ignored.
REQ-028 Operands are passed bit-exact and no arithmetic is done on them; count arithmetic is performed at width clog2(DEPTH)+1.

Reset
REQ-029 Asserting rst_n low, at any time including mid-operation, immediately clears all entry valid bits, count and iss_valid_o.
REQ-030 During and after reset, all iss_* payload outputs read 0 and disp_ready_o reads 1.

Structure
REQ-031 Typedef iq_entry_t (valid, per-source rdy/tag/data, pc, selimm, grand_op, op, wtag) and constant WIRED_RID_W live in the shared wired_pkg package.
REQ-032 One sub-module, wired_iq_entry, holds the per-entry wakeup compare and operand capture; it is instantiated DEPTH times.
REQ-033 The select priority encoder and collapse logic are written inline in wired_alu_iq.

Verification
REQ-034 Dispatch op_i=3'b001, r0=0x5, r1=0x7, both ready, iss_ready_i=1 -> next cycle iss_valid_o=1 with r0=0x5, r1=0x7, then iss_valid_o=0.
REQ-035 Dispatch with r1 not ready (tag 9); two cycles later wkup tag 9 data 0xDEAD -> iss_valid_o next cycle with iss_r1_o=0xDEAD.
REQ-036 Fill 4 entries while iss_ready_i=0 -> disp_ready_o=0, iss_* stable; release iss_ready_i -> issue order equals dispatch order.
REQ-037 Same-cycle dispatch and wakeup of its tag (bypass, REQ-019) -> issued with the forwarded value at N+1.
REQ-038 Entry 0 blocked and entry 2 ready -> entry 2 issues first, remaining entries collapse, and entry 0 issues once woken.
REQ-039 flush_i with 3 queued entries and iss_valid_o=1 -> next cycle count=0, iss_valid_o=0; rst_n pulsed mid-stall -> outputs 0 immediately.
